// File: rtl/nn_argmax_classifier.sv
`default_nettype none
// ============================================================================
// Module      : nn_argmax_classifier
// Description : Scans the output-layer score memory and reports the index and
//               value of the largest signed score plus a low-confidence flag.
//               Define NN_ARGMAX_TOP2_EN to also report runner-up and margin.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_argmax_classifier #(
    parameter int N_CLASSES = 10,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              start,
    input  logic [DATA_W-1:0] threshold,
    output logic [ADDR_W-1:0] mem_ra,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] class_idx,
    output logic [DATA_W-1:0] class_score,
    output logic              low_conf
`ifdef NN_ARGMAX_TOP2_EN
    ,
    output logic [ADDR_W-1:0]        second_idx,
    output logic signed [DATA_W:0]   margin
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(N_CLASSES - 1);
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_thr;
    logic [DATA_W-1:0] r_best;
    logic [ADDR_W-1:0] r_best_idx;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_class_idx;
    logic [DATA_W-1:0] r_class_score;
    logic              r_low_conf;
    logic              w_new_best;
    logic              w_low_conf;

    assign w_new_best = $signed(mem_rd) > $signed(r_best);

`ifdef NN_ARGMAX_TOP2_EN
    localparam logic signed [DATA_W:0] c_margin_min = (DATA_W + 1)'(256);

    logic [DATA_W-1:0]        r_second;
    logic [ADDR_W-1:0]        r_second_idx;
    logic [ADDR_W-1:0]        r_out_second_idx;
    logic signed [DATA_W:0]   r_out_margin;
    logic signed [DATA_W:0]   w_margin;
    logic                     w_new_second;

    assign w_new_second = $signed(mem_rd) > $signed(r_second);
    // Sign-extend by one bit so best minus runner-up can never overflow.
    assign w_margin     = $signed({r_best[DATA_W-1], r_best})
                        - $signed({r_second[DATA_W-1], r_second});
    assign w_low_conf   = ($signed(r_best) < $signed(r_thr)) || (w_margin < c_margin_min);
    assign second_idx   = r_out_second_idx;
    assign margin       = r_out_margin;
`else
    assign w_low_conf   = $signed(r_best) < $signed(r_thr);
`endif

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_thr         <= '0;
            r_best        <= '0;
            r_best_idx    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_class_idx   <= '0;
            r_class_score <= '0;
            r_low_conf    <= 1'b0;
`ifdef NN_ARGMAX_TOP2_EN
            r_second         <= '0;
            r_second_idx     <= '0;
            r_out_second_idx <= '0;
            r_out_margin     <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_thr   <= threshold;
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    // Element 0 seeds both trackers so later strict compares keep the lowest index on ties.
                    if (r_addr == '0) begin
                        r_best     <= mem_rd;
                        r_best_idx <= '0;
`ifdef NN_ARGMAX_TOP2_EN
                        r_second     <= mem_rd;
                        r_second_idx <= '0;
`endif
                    end else if (w_new_best) begin
                        r_best     <= mem_rd;
                        r_best_idx <= r_addr;
`ifdef NN_ARGMAX_TOP2_EN
                        r_second     <= r_best;
                        r_second_idx <= r_best_idx;
                    end else if (w_new_second) begin
                        r_second     <= mem_rd;
                        r_second_idx <= r_addr;
`endif
                    end
                    if (r_addr == c_last_addr) begin
                        r_addr  <= '0;
                        r_state <= FINISH;
                    end else begin
                        r_addr <= r_addr + c_addr_one;
                    end
                end
                FINISH: begin
                    r_class_idx   <= r_best_idx;
                    r_class_score <= r_best;
                    r_low_conf    <= w_low_conf;
`ifdef NN_ARGMAX_TOP2_EN
                    r_out_second_idx <= r_second_idx;
                    r_out_margin     <= w_margin;
`endif
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_addr  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_ra      = r_addr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign class_idx   = r_class_idx;
    assign class_score = r_class_score;
    assign low_conf    = r_low_conf;

endmodule
`default_nettype wire
